// File: rtl/decode_stage.sv
// decode_stage: ID stage of the riscky five-stage RV32I pipeline.
//
// Decodes the fetched instruction into execute-stage controls. It also holds
// the 32-entry integer register file, which writeback writes. It builds the
// sign-extended immediate and captures everything in the ID/EX register.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   instr_d, pc_d,        instruction, its PC and PC+4 from fetch
//   pc_plus4_d
//   stall_d, flush_e      hazard-unit hold / bubble controls for ID/EX
//   reg_write_w, rd_w,    writeback port into the register file
//   result_w
//   rs1_d, rs2_d          combinational source indices for the hazard unit
//   *_e                   registered ID/EX outputs consumed by execute
//
// Configuration macro: RISCKY_RF_BYPASS_EN. When it is defined, a same-cycle
// writeback to a register being read is forwarded (write-through). When it is
// undefined, the read returns the old value.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        stall_d,
  input  logic        flush_e,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_ext_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic [2:0]  funct3_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        jump_e,
  output logic        branch_e,
  output logic        alu_src_e,
  output logic        alu_src_a_e,
  output logic        illegal_e,
  output logic [1:0]  result_src_e,
  output logic [3:0]  alu_ctrl_e
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  // Register-register and register-immediate ALU op. Only R-type may select SUB;
  // instr[30] picks SRA for both forms of the right shift.
  function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic b30,
                                           input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Comparison the ALU performs for a branch: equality via SUB, signed or unsigned less-than.
  function automatic logic [3:0] alu_branch(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b100, 3'b101: op = ALU_SLT;
      3'b110, 3'b111: op = ALU_SLTU;
      default:        op = ALU_SUB;
    endcase
    return op;
  endfunction

  logic [31:0] rf [32];
  logic [31:0] rf_rd1, rf_rd2, imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        c_reg_write, c_mem_write, c_jump, c_branch, c_alu_src, c_alu_src_a, c_illegal;
  logic [1:0]  c_result_src;
  logic [3:0]  c_alu_ctrl;

  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];
  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];

  // Register file write port; reset clears it and discards a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (reg_write_w && (rd_w != 5'd0)) begin
      rf[rd_w] <= result_w;
    end
  end

  // Register file read ports; x0 is hard-wired to zero.
  always_comb begin
    rf_rd1 = 32'h0;
    rf_rd2 = 32'h0;
`ifdef RISCKY_RF_BYPASS_EN
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_d)) rf_rd1 = result_w;
    else if (rs1_d != 5'd0) rf_rd1 = rf[rs1_d];
    else rf_rd1 = 32'h0;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_d)) rf_rd2 = result_w;
    else if (rs2_d != 5'd0) rf_rd2 = rf[rs2_d];
    else rf_rd2 = 32'h0;
`else
    if (rs1_d != 5'd0) rf_rd1 = rf[rs1_d];
    else rf_rd1 = 32'h0;
    if (rs2_d != 5'd0) rf_rd2 = rf[rs2_d];
    else rf_rd2 = 32'h0;
`endif
  end

  // Opcode decode: controls and immediate format.
  always_comb begin
    c_reg_write  = 1'b0;
    c_mem_write  = 1'b0;
    c_jump       = 1'b0;
    c_branch     = 1'b0;
    c_alu_src    = 1'b0;
    c_alu_src_a  = 1'b0;
    c_illegal    = 1'b0;
    c_result_src = 2'b00;
    c_alu_ctrl   = ALU_ADD;
    imm          = 32'h0;
    case (opcode)
      OP_R: begin
        c_reg_write = 1'b1;
        c_alu_ctrl  = alu_arith(funct3, instr_d[30], 1'b1);
      end
      OP_IMM: begin
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_ctrl  = alu_arith(funct3, instr_d[30], 1'b0);
        imm         = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_LOAD: begin
        c_reg_write  = 1'b1;
        c_alu_src    = 1'b1;
        c_result_src = 2'b01;
        imm          = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_STORE: begin
        c_mem_write = 1'b1;
        c_alu_src   = 1'b1;
        imm         = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      end
      OP_BRANCH: begin
        c_branch   = 1'b1;
        c_alu_ctrl = alu_branch(funct3);
        imm        = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      end
      OP_JAL: begin
        c_reg_write  = 1'b1;
        c_jump       = 1'b1;
        c_result_src = 2'b10;
        imm = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      end
      OP_JALR: begin
        c_reg_write  = 1'b1;
        c_jump       = 1'b1;
        c_alu_src    = 1'b1;
        c_result_src = 2'b10;
        imm          = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_LUI: begin
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_ctrl  = ALU_PASS;
        imm         = {instr_d[31:12], 12'h000};
      end
      OP_AUIPC: begin
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_src_a = 1'b1;
        imm         = {instr_d[31:12], 12'h000};
      end
      default: c_illegal = 1'b1;
    endcase
  end

  // ID/EX pipeline register: reset and flush both zero it (a bubble), stall holds it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      rd1_e        <= 32'h0;
      rd2_e        <= 32'h0;
      imm_ext_e    <= 32'h0;
      pc_e         <= 32'h0;
      pc_plus4_e   <= 32'h0;
      rs1_e        <= 5'd0;
      rs2_e        <= 5'd0;
      rd_e         <= 5'd0;
      funct3_e     <= 3'd0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      alu_src_a_e  <= 1'b0;
      illegal_e    <= 1'b0;
      result_src_e <= 2'b00;
      alu_ctrl_e   <= 4'b0000;
    end else if (!stall_d) begin
      rd1_e        <= rf_rd1;
      rd2_e        <= rf_rd2;
      imm_ext_e    <= imm;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= instr_d[11:7];
      funct3_e     <= funct3;
      reg_write_e  <= c_reg_write;
      mem_write_e  <= c_mem_write;
      jump_e       <= c_jump;
      branch_e     <= c_branch;
      alu_src_e    <= c_alu_src;
      alu_src_a_e  <= c_alu_src_a;
      illegal_e    <= c_illegal;
      result_src_e <= c_result_src;
      alu_ctrl_e   <= c_alu_ctrl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of directed decode vectors,
// then hand-written sequences for bypass, stall/flush, and mid-stream reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        stall_d, flush_e, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [2:0]  funct3_e;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_src_a_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_ctrl_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .stall_d(stall_d), .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .funct3_e(funct3_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .alu_src_a_e(alu_src_a_e), .illegal_e(illegal_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e)
  );

  typedef struct {
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic [6:0]  e_ctl;   // {reg_write, mem_write, jump, branch, alu_src, alu_src_a, illegal}
    logic [1:0]  e_rs;
    logic [3:0]  e_alu;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [6:0] ctl_now();
    return {reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_src_a_e, illegal_e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic stall,
                       input logic flush, input logic wen, input logic [4:0] wrd,
                       input logic [31:0] wdata);
    instr_d     = instr;
    pc_d        = pc;
    pc_plus4_d  = pc + 32'd4;
    stall_d     = stall;
    flush_e     = flush;
    reg_write_w = wen;
    rd_w        = wrd;
    result_w    = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h00000013, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 7'b1000100, 2'b00, 4'h0};
    vecs[1]  = '{32'h00028333, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd6, 3'd0, 7'b1000000, 2'b00, 4'h0};
    vecs[2]  = '{32'hFFF00093, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd1, 3'd0, 7'b1000100, 2'b00, 4'h0};
    vecs[3]  = '{32'hFE000EE3, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd29, 3'd0, 7'b0001000, 2'b00, 4'h1};
    vecs[4]  = '{32'h00000013, 1'b1, 5'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 7'b1000100, 2'b00, 4'h0};
    vecs[5]  = '{32'h00000333, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 3'd0, 7'b1000000, 2'b00, 4'h0};
    vecs[6]  = '{32'h0052A623, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000000C, 5'd12, 3'd2, 7'b0100100, 2'b00, 4'h0};
    vecs[7]  = '{32'hFF02A483, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFF0, 5'd9, 3'd2, 7'b1000100, 2'b01, 4'h0};
    vecs[8]  = '{32'h12345537, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h12345000, 5'd10, 3'd5, 7'b1000100, 2'b00, 4'hA};
    vecs[9]  = '{32'hFFFFF597, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFF000, 5'd11, 3'd7, 7'b1000110, 2'b00, 4'h0};
    vecs[10] = '{32'h008000EF, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000008, 5'd1, 3'd0, 7'b1010000, 2'b10, 4'h0};
    vecs[11] = '{32'h00008067, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 7'b1010100, 2'b10, 4'h0};
    vecs[12] = '{32'h40528633, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd12, 3'd0, 7'b1000000, 2'b00, 4'h1};
    vecs[13] = '{32'h4032D693, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h00000403, 5'd13, 3'd5, 7'b1000100, 2'b00, 4'h9};
    vecs[14] = '{32'h0002D733, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd14, 3'd5, 7'b1000000, 2'b00, 4'h8};
    vecs[15] = '{32'h0002C463, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h00000008, 5'd8, 3'd4, 7'b0001000, 2'b00, 4'h5};
    vecs[16] = '{32'h0002F463, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h00000008, 5'd8, 3'd7, 7'b0001000, 2'b00, 4'h6};
    vecs[17] = '{32'h0000007F, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 7'b0000001, 2'b00, 4'h0};
    vecs[18] = '{32'h0052F7B3, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd15, 3'd7, 7'b1000000, 2'b00, 4'h2};

    // Reset state: two cycles with rst_n low.
    rst_n = 1'b0;
    drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    step();
    chk("reset_ctl", {25'h0, ctl_now()}, 32'h0);
    chk("reset_rd1", rd1_e, 32'h0);
    chk("reset_imm", imm_ext_e, 32'h0);
    chk("reset_pc", pc_e, 32'h0);
    chk("reset_misc", {rd_e, funct3_e, result_src_e, alu_ctrl_e}, 32'h0);
    rst_n = 1'b1;

    // Table-driven decode vectors.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].instr, 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b0, vecs[i].wen, vecs[i].wrd,
            vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_rs1_d", i), {27'h0, rs1_d}, {27'h0, vecs[i].instr[19:15]});
      step();
      chk($sformatf("v%0d_ctl", i), {25'h0, ctl_now()}, {25'h0, vecs[i].e_ctl});
      chk($sformatf("v%0d_rd1", i), rd1_e, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2_e, vecs[i].e_rd2);
      chk($sformatf("v%0d_imm", i), imm_ext_e, vecs[i].e_imm);
      chk($sformatf("v%0d_rd", i), {27'h0, rd_e}, {27'h0, vecs[i].e_rd});
      chk($sformatf("v%0d_f3", i), {29'h0, funct3_e}, {29'h0, vecs[i].e_f3});
      chk($sformatf("v%0d_rsrc", i), {30'h0, result_src_e}, {30'h0, vecs[i].e_rs});
      chk($sformatf("v%0d_alu", i), {28'h0, alu_ctrl_e}, {28'h0, vecs[i].e_alu});
      chk($sformatf("v%0d_pc", i), pc_e, 32'h1000 + 32'(i) * 32'd4);
      chk($sformatf("v%0d_pc4", i), pc_plus4_e, 32'h1004 + 32'(i) * 32'd4);
    end

    // Same-cycle write of x7 while decoding add x16,x7,x0.
    drive(32'h00038833, 32'h2000, 1'b0, 1'b0, 1'b1, 5'd7, 32'h55);
    step();
`ifdef RISCKY_RF_BYPASS_EN
    chk("bypass_rd1", rd1_e, 32'h55);
`else
    chk("bypass_rd1", rd1_e, 32'h0);
`endif
    drive(32'h00038833, 32'h2004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("after_write_rd1", rd1_e, 32'h55);

    // Stall hold with jal x1 loaded; a writeback to x20 lands during the stall.
    drive(32'h008000EF, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("jal_load_ctl", {25'h0, ctl_now()}, {25'h0, 7'b1010000});
    for (int c = 0; c < 2; c++) begin
      drive(32'h0000007F, 32'h300, 1'b1, 1'b0, (c == 0), 5'd20, 32'h77);
      step();
      chk($sformatf("stall%0d_ctl", c), {25'h0, ctl_now()}, {25'h0, 7'b1010000});
      chk($sformatf("stall%0d_rd", c), {27'h0, rd_e}, 32'd1);
      chk($sformatf("stall%0d_pc", c), pc_e, 32'h200);
      chk($sformatf("stall%0d_imm", c), imm_ext_e, 32'h8);
      chk($sformatf("stall%0d_rsrc", c), {30'h0, result_src_e}, 32'd2);
    end
    drive(32'h0000007F, 32'h300, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    chk("flush_ctl", {25'h0, ctl_now() & 7'b1111001}, 32'h0);
    chk("flush_rd", {27'h0, rd_e}, 32'h0);
    drive(32'h000A0333, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("stall_write_x20", rd1_e, 32'h77);

    // Mid-stream reset discards ID/EX, clears the register file, drops a coincident write.
    drive(32'h00028333, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("pre_reset_rd1", rd1_e, 32'hDEADBEEF);
    rst_n = 1'b0;
    drive(32'h00028333, 32'h404, 1'b0, 1'b0, 1'b1, 5'd21, 32'h99);
    step();
    chk("midrst_ctl", {25'h0, ctl_now()}, 32'h0);
    chk("midrst_rd1", rd1_e, 32'h0);
    chk("midrst_rd_pc", {rd_e, pc_e[26:0]}, 32'h0);
    rst_n = 1'b1;
    drive(32'h00028333, 32'h408, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("x5_cleared", rd1_e, 32'h0);
    chk("x5_cleared_ctl", {25'h0, ctl_now()}, {25'h0, 7'b1000000});
    drive(32'h000A8333, 32'h40C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("x21_write_lost", rd1_e, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
